// File: rtl/kbd_event_arbiter.sv
// Merges PS/2 scan codes and serialized USB HID reports into one tagged byte-event
// stream. Arbitration is round-robin, and events are buffered in a show-ahead FIFO.
module kbd_event_arbiter #(
  parameter int FIFO_DEPTH          = 16,
  parameter int USB_REPORT_NB_BYTES = 8,
  parameter int USB_DEDUP           = 1
) (
  input  logic                               clk,
  input  logic                               reset_i,
  input  logic [7:0]                         ps2_code_i,
  input  logic                               ps2_strobe_i,
  input  logic                               ps2_err_i,
  input  logic [USB_REPORT_NB_BYTES*8-1:0]   usb_report_i,
  input  logic                               usb_report_valid_i,
  output logic [7:0]                         ev_data_o,
  output logic                               ev_src_o,
  output logic                               ev_last_o,
  output logic                               ev_valid_o,
  input  logic                               ev_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]        level_o,
  output logic                               ovf_o,
  input  logic                               ovf_clr_i,
  output logic [7:0]                         ps2_err_cnt_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = (USB_REPORT_NB_BYTES > 1) ? $clog2(USB_REPORT_NB_BYTES) : 1;

  typedef struct packed {
    logic       src;
    logic       last;
    logic [7:0] data;
  } ev_t;

  typedef enum logic {S_IDLE, S_SEND} usb_st_t;

  // FIFO state
  ev_t             mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, pop, wr;
  ev_t             wr_ev, head;

  // sources
  logic            ps2_vld;
  logic [7:0]      ps2_code;
  usb_st_t         usb_st;
  logic [IW-1:0]   idx;
  logic [USB_REPORT_NB_BYTES-1:0][7:0] shadow;
  logic [USB_REPORT_NB_BYTES*8-1:0]    last_report;
  logic            rr_usb;

  logic            req_ps2, req_usb, gnt_ps2, gnt_usb;
  logic            usb_last, usb_dup, usb_drop, ps2_take, ps2_drop;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign pop      = ev_valid_o && ev_ready_i;
  assign req_ps2  = ps2_vld;
  assign req_usb  = (usb_st == S_SEND);
  assign usb_last = (idx == IW'(USB_REPORT_NB_BYTES-1));
  assign usb_dup  = (USB_DEDUP != 0) && (usb_report_i == last_report);
  assign usb_drop = usb_report_valid_i && (usb_st == S_SEND);
  assign ps2_take = ps2_strobe_i && !ps2_err_i;
  // a code arriving while the pending slot is neither empty nor draining is lost
  assign ps2_drop = ps2_take && ps2_vld && !gnt_ps2;

  always_comb begin
    gnt_ps2 = 1'b0;
    gnt_usb = 1'b0;
    if (!full) begin
      if (req_ps2 && req_usb) begin
        gnt_usb = rr_usb;
        gnt_ps2 = !rr_usb;
      end else begin
        gnt_ps2 = req_ps2;
        gnt_usb = req_usb;
      end
    end
  end

  assign wr    = gnt_ps2 || gnt_usb;
  assign wr_ev = gnt_ps2 ? ev_t'{src: 1'b0, last: 1'b1, data: ps2_code}
                         : ev_t'{src: 1'b1, last: usb_last, data: shadow[idx]};

  // round-robin pointer moves only when both sides contended
  always_ff @(posedge clk) begin
    if (reset_i)                 rr_usb <= 1'b0;
    else if (gnt_ps2 && req_usb) rr_usb <= 1'b1;
    else if (gnt_usb && req_ps2) rr_usb <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      ps2_vld       <= 1'b0;
      ps2_code      <= '0;
      ps2_err_cnt_o <= '0;
    end else begin
      if (ps2_take && !ps2_drop) begin
        ps2_vld  <= 1'b1;
        ps2_code <= ps2_code_i;
      end else if (gnt_ps2) begin
        ps2_vld  <= 1'b0;
      end
      if (ps2_strobe_i && ps2_err_i && ps2_err_cnt_o != 8'hFF)
        ps2_err_cnt_o <= ps2_err_cnt_o + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      usb_st      <= S_IDLE;
      idx         <= '0;
      shadow      <= '0;
      last_report <= '0;
    end else begin
      case (usb_st)
        S_IDLE: if (usb_report_valid_i && !usb_dup) begin
          shadow      <= usb_report_i;
          last_report <= usb_report_i;
          idx         <= '0;
          usb_st      <= S_SEND;
        end
        S_SEND: if (gnt_usb) begin
          if (usb_last) begin
            idx    <= '0;
            usb_st <= S_IDLE;
          end else begin
            idx    <= idx + IW'(1);
          end
        end
        default: usb_st <= S_IDLE;
      endcase
    end
  end

  // set beats clear when both happen in one cycle
  always_ff @(posedge clk) begin
    if (reset_i)                    ovf_o <= 1'b0;
    else if (ps2_drop || usb_drop)  ovf_o <= 1'b1;
    else if (ovf_clr_i)             ovf_o <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_ev;
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign ev_valid_o = (count != '0);
  assign head       = ev_valid_o ? mem[rd_ptr] : '0;
  assign ev_data_o  = head.data;
  assign ev_src_o   = head.src;
  assign ev_last_o  = head.last;
  assign level_o    = count;

endmodule
